// File: rtl/uart_count_reporter_if.sv
// Count/handshake bundle between the stopwatch counter and its UART reporter.
// The counter side drives number/enable; the reporter drives the line and status.
interface uart_count_reporter_if #(
   parameter int NUMBER_OF_DIGITS = 4
);
   logic [4*NUMBER_OF_DIGITS-1:0] number;
   logic                          enable;
   logic                          tx;
   logic                          busy;
   logic                          frame_done;

   modport master (
      output number,
      output enable,
      input  tx,
      input  busy,
      input  frame_done
   );

   modport slave (
      input  number,
      input  enable,
      output tx,
      output busy,
      output frame_done
   );
endinterface

// File: rtl/uart_count_reporter.sv
// Sends the stopwatch count as uppercase ASCII hex plus CR LF over an 8N1 UART
// whenever it differs from the last value sent, so a host terminal mirrors the display.
module uart_count_reporter #(
   parameter int NUMBER_OF_DIGITS            = 4,
   parameter int BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
   parameter int BAUD_RATE                   = 115200
) (
   input logic                  clk,
   input logic                  rst_n,
   uart_count_reporter_if.slave bus
);

   localparam int W            = 4 * NUMBER_OF_DIGITS;
   localparam int CLKS_PER_BIT = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE;
   localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CIW          = $clog2(NUMBER_OF_DIGITS + 2);

   localparam logic [CW-1:0]  CNT_MAX   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CIW-1:0] DIGITS    = CIW'(NUMBER_OF_DIGITS);
   localparam logic [CIW-1:0] LAST_CHAR = CIW'(NUMBER_OF_DIGITS + 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t         state;
   logic [CW-1:0]  clk_cnt;
   logic [2:0]     bit_idx;
   logic [CIW-1:0] char_idx;
   logic [W-1:0]   snap;
   logic [W-1:0]   last_sent;
   logic           sent_once;
   logic [7:0]     tx_byte;
   logic           tx_q;
   logic           busy_q;
   logic           done_q;

   logic           bit_end;
   logic           start_req;
   logic [CIW-1:0] next_idx;
   logic [7:0]     next_byte;

   function automatic logic [7:0] hex_ascii(input logic [3:0] d);
      if (d < 4'd10)
         return 8'h30 + {4'h0, d};
      else
         return 8'h37 + {4'h0, d};
   endfunction

   assign bit_end   = (clk_cnt == CNT_MAX);
   assign start_req = bus.enable && (!sent_once || (bus.number != last_sent));
   assign next_idx  = char_idx + 1'b1;

   // Character that follows the current one: next digit, then CR, then LF.
   always_comb begin
      next_byte = 8'h0A;
      unique case (1'b1)
         (next_idx < DIGITS):  next_byte = hex_ascii(snap[W-1 -: 4]);
         (next_idx == DIGITS): next_byte = 8'h0D;
         default:              next_byte = 8'h0A;
      endcase
   end

   // Frame sequencer; tx is only ever driven from this flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         clk_cnt   <= '0;
         bit_idx   <= '0;
         char_idx  <= '0;
         snap      <= '0;
         last_sent <= '0;
         sent_once <= 1'b0;
         tx_byte   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            IDLE: begin
               clk_cnt <= '0;
               if (start_req) begin
                  state     <= START;
                  tx_q      <= 1'b0;
                  busy_q    <= 1'b1;
                  last_sent <= bus.number;
                  sent_once <= 1'b1;
                  snap      <= bus.number << 4;
                  tx_byte   <= hex_ascii(bus.number[W-1 -: 4]);
                  char_idx  <= '0;
                  bit_idx   <= '0;
               end
            end
            START: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  bit_idx <= '0;
                  tx_q    <= tx_byte[0];
                  tx_byte <= tx_byte >> 1;
                  state   <= DATA;
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     tx_q  <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx_q    <= tx_byte[0];
                     tx_byte <= tx_byte >> 1;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  clk_cnt <= '0;
                  if (char_idx == LAST_CHAR) begin
                     char_idx <= '0;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     char_idx <= next_idx;
                     tx_byte  <= next_byte;
                     snap     <= snap << 4;
                     tx_q     <= 1'b0;
                     state    <= START;
                  end
               end else begin
                  clk_cnt <= clk_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.tx         = tx_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_count_reporter.sv
// Directed bench for uart_count_reporter at 10 clocks per bit.
// Decodes the serial line and checks bytes, bit timing and frame status.
module tb_uart_count_reporter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int          checks = 0;
   int          failures = 0;
   int unsigned cyc = 0;

   uart_count_reporter_if #(.NUMBER_OF_DIGITS(4)) bus ();

   uart_count_reporter #(
      .NUMBER_OF_DIGITS            (4),
      .BOARD_CLOCK_FREQUENCY_IN_HZ (1000),
      .BAUD_RATE                   (100)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic recv_frame(input string tag, input logic [47:0] exp);
      int          waited;
      int          stray;
      int          nobusy;
      int          bad;
      int unsigned t0;
      logic [7:0]  b;
      logic        first;
      logic        v;
      waited = 0;
      stray  = 0;
      nobusy = 0;
      bad    = 0;
      first  = 1'b0;
      b      = '0;
      do begin
         @(negedge clk);
         waited++;
         if (bus.frame_done !== 1'b0) stray++;
      end while (bus.tx !== 1'b0 && waited < 20);
      check({tag, "_lat"}, waited, 1);
      if (bus.tx !== 1'b0) return;
      t0 = cyc;
      for (int c = 0; c < 6; c++) begin
         for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < 10; j++) begin
               if (!(c == 0 && k == 0 && j == 0)) @(negedge clk);
               v = bus.tx;
               if (j == 0) first = v;
               else if (v !== first) bad++;
               if (bus.frame_done !== 1'b0) stray++;
               if (bus.busy !== 1'b1) nobusy++;
               if (k == 0 && v !== 1'b0) bad++;
               if (k == 9 && v !== 1'b1) bad++;
               if (k >= 1 && k <= 8 && j == 0) b[k-1] = v;
            end
         end
         check($sformatf("%s_ch%0d", tag, c), b, exp[47-8*c -: 8]);
      end
      @(negedge clk);
      check({tag, "_len"}, cyc - t0, 600);
      check({tag, "_done"}, bus.frame_done, 1);
      check({tag, "_busy_end"}, bus.busy, 0);
      check({tag, "_tx_end"}, bus.tx, 1);
      check({tag, "_framing"}, bad, 0);
      check({tag, "_stray_done"}, stray, 0);
      check({tag, "_busy_in"}, nobusy, 0);
   endtask

   task automatic hold(input string tag, input int n);
      int txl;
      int bh;
      int fh;
      txl = 0;
      bh  = 0;
      fh  = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (bus.tx !== 1'b1) txl++;
         if (bus.busy !== 1'b0) bh++;
         if (bus.frame_done !== 1'b0) fh++;
      end
      check({tag, "_tx"}, txl, 0);
      check({tag, "_busy"}, bh, 0);
      check({tag, "_done"}, fh, 0);
   endtask

   initial begin
      int w;
      bus.number = 16'h0000;
      bus.enable = 1'b1;
      rst_n      = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx", bus.tx, 1);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.frame_done, 0);

      rst_n = 1'b1;
      recv_frame("f0000", 48'h3030_3030_0D0A);

      hold("idle0", 50);
      bus.number = 16'h1A2F;
      recv_frame("f1a2f", 48'h3141_3246_0D0A);

      bus.number = 16'h0001;
      fork
         recv_frame("f0001", 48'h3030_3031_0D0A);
         begin
            repeat (100) @(negedge clk);
            bus.number = 16'h0002;
            repeat (200) @(negedge clk);
            bus.number = 16'h0003;
         end
      join
      recv_frame("f0003", 48'h3030_3033_0D0A);

      hold("hold3000", 3000);

      bus.enable = 1'b0;
      bus.number = 16'h00BE;
      hold("en0a", 200);
      bus.number = 16'hC0DE;
      hold("en0b", 200);
      bus.enable = 1'b1;
      fork
         recv_frame("fc0de", 48'h4330_4445_0D0A);
         begin
            repeat (100) @(negedge clk);
            bus.enable = 1'b0;
         end
      join
      hold("en0c", 100);

      bus.number = 16'h5A5A;
      bus.enable = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (bus.tx !== 1'b0 && w < 20);
      check("f5a5a_start", bus.tx, 0);
      repeat (249) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_tx", bus.tx, 1);
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.frame_done, 0);
      @(negedge clk);
      rst_n = 1'b1;
      recv_frame("f5a5a_again", 48'h3541_3541_0D0A);
      hold("final", 100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_count_reporter.md
# uart_count_reporter

Serial reporter for the stopwatch count. It sits downstream of the counter, in parallel with the seven-segment display driver, and sends the current count to the host over the USB-UART `usb_tx` line as uppercase ASCII hex followed by CR LF. It sends a frame whenever the count differs from the last value sent, so a terminal on the host mirrors the display.

## Interface
Parameters:
- `NUMBER_OF_DIGITS`, 4: number of hex digits reported; count width is 4*NUMBER_OF_DIGITS.
- `BOARD_CLOCK_FREQUENCY_IN_HZ`, 100_000_000: frequency of `clk`.
- `BAUD_RATE`, 115200: UART bit rate.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `number`, input, 4*NUMBER_OF_DIGITS: count to report; most-significant digit is sent first.
- `enable`, input, 1: permits new frames to start.
- `tx`, output, 1: UART line, 8N1, idles high.
- `busy`, output, 1: a frame is in progress.
- `frame_done`, output, 1: one-cycle pulse when a frame's last stop bit ends.

## Operation
- Bit period is `CLKS_PER_BIT` = BOARD_CLOCK_FREQUENCY_IN_HZ / BAUD_RATE, using integer truncation. The default is 868. `CLKS_PER_BIT` must be at least 2.
- Character format:
  - Start bit 0.
  - 8 data bits, LSB first.
  - 1 stop bit (1).
  - Every bit lasts exactly CLKS_PER_BIT cycles.
- Frame content is NUMBER_OF_DIGITS characters, then 0x0D, then 0x0A.
  - Digit values 0–9 map to 0x30–0x39.
  - Digit values A–F map to 0x41–0x46 (uppercase).
- Characters within a frame are sent back-to-back, with no idle bits between a stop bit and the next start bit.
- Internal state: `last_sent` register (count width) and `sent_once` flag. Both are cleared by reset.
- Start condition, evaluated only in IDLE: `enable`=1 AND (`sent_once`=0 OR `number` != `last_sent`).
- On the start edge:
  - `number` is snapshotted into both the shift source and `last_sent`.
  - `sent_once` is set.
  - The FSM goes to START.
- The snapshot is the only value transmitted. Changes to `number` during a frame are ignored until IDLE. After the frame, only the latest value is compared, so intermediate values are dropped.
- FSM states and transitions:
  - IDLE → START: on the start condition.
  - START → DATA: after one bit period.
  - DATA → STOP: after 8 bit periods.
  - STOP → START: after one bit period, if characters remain in the frame.
  - STOP → IDLE: after one bit period, on the last character.
- Counters: a character index runs 0..NUMBER_OF_DIGITS+1, and a bit index runs 0..7.
- `enable` falling mid-frame does not abort the frame; the frame completes.
- Reset (any time, including mid-frame) drives the block to IDLE immediately:
  - `tx`=1, `busy`=0, `frame_done`=0.
  - Counters and `sent_once` are cleared.
  - After release, the first frame is re-sent.

## Timing
- Reset values: `tx`=1, `busy`=0, `frame_done`=0. All outputs are registered.
- `tx` falls (start bit) and `busy` rises on the same edge that samples the start condition, so the latency from the start condition to the start bit is 0 cycles after that edge.
- Frame duration: (NUMBER_OF_DIGITS+2)*10*CLKS_PER_BIT cycles, from the first start bit to the end of the last stop bit. The default is 52080 cycles.
- On the edge ending the last stop bit:
  - `busy` falls.
  - `frame_done` is high for exactly one cycle.
  - The FSM enters IDLE.
- The earliest next start edge is one cycle after that edge. `tx` therefore spends at least one cycle idle high between frames.
- `tx` is glitch-free: it is driven from a flop.

## Test plan
Bench parameters: BOARD_CLOCK_FREQUENCY_IN_HZ=1000, BAUD_RATE=100, giving CLKS_PER_BIT=10.
- Release reset with `number`=0x0000, `enable`=1.
  - Required: start bit on the first edge after release.
  - Decoded bytes: 0x30 0x30 0x30 0x30 0x0D 0x0A.
  - Each bit lasts 10 cycles; frame length is 600 cycles.
  - One `frame_done` pulse, coincident with `busy` falling.
- Apply `number`=0x1A2F after idle.
  - Required bytes: 0x31 0x41 0x32 0x46 0x0D 0x0A (uppercase hex).
- During a frame of 0x0001, step `number` to 0x0002, then to 0x0003.
  - The current frame still carries 0x0001.
  - The next frame starts 1 cycle after `frame_done` and carries 0x0003.
  - 0x0002 is never sent.
- Hold `number` constant for 3000 cycles after a frame.
  - `tx` stays 1, `busy` stays 0, no `frame_done`.
- Hold `enable`=0 while `number` changes.
  - No frame is sent.
  - Raise `enable`: a frame with the current value starts on that edge.
  - Drop `enable` mid-frame: the frame still completes all 600 cycles.
- Assert `rst_n`=0 at cycle 250 of a frame.
  - `tx`=1 and `busy`=0 without waiting for a clock edge.
  - After release, the same value is sent again in full.
